traffic_intersection_ctrl: RTL

Two-approach intersection controller: main road (NS) and side road (EW). Generalises the single-lamp RED/GREEN/YELLOW sequencer in four ways:
- per-phase parametrised durations
- tick-enable timebase
- all-red clearance intervals
- demand-actuated main-road green hold, plus a pedestrian walk signal for the side road.

It sits between the board prescaler (tick source) and the lamp drivers.

---
 rtl/traffic_intersection_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller: NS main road, EW side road, tick-enable timebase,
// all-red clearance, demand-held NS green and EW pedestrian walk. Define FLASH_MODE_EN for flash mode.
module traffic_intersection_ctrl #(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned GREEN_TICKS  = 6,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned WALK_TICKS   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       ew_req,
`ifdef FLASH_MODE_EN
    input  logic       flash_req,
`endif
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       walk_ew,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
`ifdef FLASH_MODE_EN
        , FLASH   = 3'd6
`endif
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
`ifdef FLASH_MODE_EN
    localparam logic [2:0] LAMP_OFF = 3'b000;
`endif

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LIM    = CNT_W'(WALK_TICKS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_pending;
`ifdef FLASH_MODE_EN
    logic             blink;
`endif

    logic [CNT_W-1:0] phase_last;
    state_t           phase_next;
    logic             legal;
    logic             enter_ew;

    // Per-phase terminal count and successor for the fixed-length phases.
    always_comb begin
        phase_last = '0;
        phase_next = ALLRED_A;
        legal      = 1'b1;
        case (state)
            ALLRED_A:  begin phase_last = ALLRED_LAST; phase_next = NS_GREEN;  end
            NS_GREEN:  begin phase_last = GREEN_LAST;  phase_next = NS_YELLOW; end
            NS_YELLOW: begin phase_last = YELLOW_LAST; phase_next = ALLRED_B;  end
            ALLRED_B:  begin phase_last = ALLRED_LAST; phase_next = EW_GREEN;  end
            EW_GREEN:  begin phase_last = GREEN_LAST;  phase_next = EW_YELLOW; end
            EW_YELLOW: begin phase_last = YELLOW_LAST; phase_next = ALLRED_A;  end
            default:   legal = 1'b0;
        endcase
    end

`ifdef FLASH_MODE_EN
    assign enter_ew = tick_en && !flash_req && (state == ALLRED_B) && (cnt == ALLRED_LAST);
`else
    assign enter_ew = tick_en && (state == ALLRED_B) && (cnt == ALLRED_LAST);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ALLRED_A;
            cnt         <= '0;
            req_pending <= 1'b0;
`ifdef FLASH_MODE_EN
            blink       <= 1'b0;
`endif
        end else begin
            // A new request on the EW_GREEN entry edge survives the clear.
            req_pending <= ew_req | (req_pending & ~enter_ew);
`ifdef FLASH_MODE_EN
            if (flash_req) begin
                if (state != FLASH) begin
                    state <= FLASH;
                    cnt   <= '0;
                    blink <= 1'b0;
                end else if (tick_en) begin
                    blink <= ~blink;
                end
            end else if (state == FLASH) begin
                state <= ALLRED_A;
                cnt   <= '0;
            end else
`endif
            if (!legal) begin
                state <= ALLRED_A;
                cnt   <= '0;
            end else if (tick_en) begin
                if (state == NS_GREEN) begin
                    // NS green holds with cnt saturated until side-road demand is seen.
                    if (cnt >= GREEN_LAST && req_pending) begin
                        state <= NS_YELLOW;
                        cnt   <= '0;
                    end else if (cnt < GREEN_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (cnt == phase_last) begin
                    state <= phase_next;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ns_lights = LAMP_RED;
        ew_lights = LAMP_RED;
        walk_ew   = 1'b0;
        case (state)
            NS_GREEN:  ns_lights = LAMP_GRN;
            NS_YELLOW: ns_lights = LAMP_YEL;
            EW_GREEN:  begin
                ew_lights = LAMP_GRN;
                walk_ew   = (cnt < WALK_LIM);
            end
            EW_YELLOW: ew_lights = LAMP_YEL;
`ifdef FLASH_MODE_EN
            FLASH:     begin
                ns_lights = blink ? LAMP_YEL : LAMP_OFF;
                ew_lights = blink ? LAMP_RED : LAMP_OFF;
            end
`endif
            default:   ;
        endcase
    end

    assign phase = state;

endmodule
